// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Contents: FSM state encoding, line geometry constants, and helpers that
// derive the index/tag widths from the number of lines and the word size.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int OFFSET_W       = 2;
   localparam int WORDS_PER_LINE = 4;
   localparam int BLOCK_W        = 64;

   function automatic int index_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_w(input int word_size, input int num_lines);
      return word_size - OFFSET_W - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side request/response lines plus memory-side block-read / word-write
// handshake of the data cache controller.
//   cpu_read, cpu_write, cpu_addr, cpu_wdata : request from the MEM stage
//   cpu_rdata, cpu_done                      : response (done is a 1-cycle pulse)
//   mem_read, mem_write, mem_addr, mem_wdata : request to external memory
//   mem_rdata, mem_ready                     : memory response (ready is a pulse)
// Modports: master = pipeline + memory environment, slave = the controller.
interface dcache_ctrl_if
   import cache_pkg::*;
#(
   parameter int WORD_SIZE = 16
);
   logic                 cpu_read;
   logic                 cpu_write;
   logic [WORD_SIZE-1:0] cpu_addr;
   logic [WORD_SIZE-1:0] cpu_wdata;
   logic [WORD_SIZE-1:0] cpu_rdata;
   logic                 cpu_done;
   logic                 mem_read;
   logic                 mem_write;
   logic [WORD_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [BLOCK_W-1:0]   mem_rdata;
   logic                 mem_ready;

   modport master (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
      input  cpu_rdata, cpu_done, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
      output cpu_rdata, cpu_done, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache.
//   clk, reset_n            : clock, async active-low reset (clears valid bits)
//   lookup_addr -> hit,
//                  rd_word  : combinational lookup of one word address
//   fill_en, fill_block     : write a whole line (tag updated, valid set)
//   word_en, word_data      : overwrite one word of a resident line
//   wr_addr                 : word address used by either write
module cache_line_array
   import cache_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] lookup_addr,
   output logic                 hit,
   output logic [WORD_SIZE-1:0] rd_word,
   input  logic                 fill_en,
   input  logic                 word_en,
   input  logic [WORD_SIZE-1:0] wr_addr,
   input  logic [BLOCK_W-1:0]   fill_block,
   input  logic [WORD_SIZE-1:0] word_data
);
   localparam int IW = index_w(NUM_LINES);
   localparam int TW = tag_w(WORD_SIZE, NUM_LINES);

   logic [NUM_LINES-1:0] valid;
   logic [TW-1:0]        tags [NUM_LINES];
   logic [BLOCK_W-1:0]   data [NUM_LINES];

   logic [OFFSET_W-1:0]  lk_off, wr_off;
   logic [IW-1:0]        lk_idx, wr_idx;
   logic [TW-1:0]        lk_tag, wr_tag;

   assign lk_off = lookup_addr[OFFSET_W-1:0];
   assign lk_idx = lookup_addr[OFFSET_W +: IW];
   assign lk_tag = lookup_addr[WORD_SIZE-1 -: TW];
   assign wr_off = wr_addr[OFFSET_W-1:0];
   assign wr_idx = wr_addr[OFFSET_W +: IW];
   assign wr_tag = wr_addr[WORD_SIZE-1 -: TW];

   assign hit     = valid[lk_idx] && (tags[lk_idx] == lk_tag);
   assign rd_word = data[lk_idx][int'(lk_off) * WORD_SIZE +: WORD_SIZE];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         valid <= '0;
      else if (fill_en)
         valid[wr_idx] <= 1'b1;
   end

   // NOTE: tag/data arrays are deliberately not reset; the valid bits alone
   // make their power-up contents unobservable, and a reset-free array can
   // map onto plain RAM.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= fill_block;
      end else if (word_en) begin
         data[wr_idx][int'(wr_off) * WORD_SIZE +: WORD_SIZE] <= word_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
//   clk, reset_n : clock, async active-low reset
//   bus          : CPU request/response and memory handshake (slave modport)
//   num_hit      : saturating count of accepted accesses that hit
//   num_miss     : saturating count of accepted accesses that missed
// Requests are only sampled in IDLE; every access ends with a one-cycle
// cpu_done in RESP, so back-to-back accesses are at least two cycles apart.
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   dcache_ctrl_if.slave         bus,
   output logic [WORD_SIZE-1:0] num_hit,
   output logic [WORD_SIZE-1:0] num_miss
);
   state_t               state, next_state;
   logic [WORD_SIZE-1:0] addr_q, wdata_q, rdata_q, mem_addr_q;
   logic                 lk_hit;
   logic [WORD_SIZE-1:0] lk_word, fill_word, wr_addr;
   logic                 accept, fill_en, word_en;

   // A simultaneous read+write request is treated as a write everywhere,
   // so cpu_write alone decides the access type once accepted.
   assign accept    = (state == IDLE) && (bus.cpu_read || bus.cpu_write);
   assign fill_en   = (state == FILL) && bus.mem_ready;
   assign word_en   = accept && bus.cpu_write && lk_hit;
   assign wr_addr   = fill_en ? addr_q : bus.cpu_addr;
   assign fill_word = bus.mem_rdata[int'(addr_q[OFFSET_W-1:0]) * WORD_SIZE +: WORD_SIZE];

   cache_line_array #(
      .NUM_LINES (NUM_LINES),
      .WORD_SIZE (WORD_SIZE)
   ) u_lines (
      .clk         (clk),
      .reset_n     (reset_n),
      .lookup_addr (bus.cpu_addr),
      .hit         (lk_hit),
      .rd_word     (lk_word),
      .fill_en     (fill_en),
      .word_en     (word_en),
      .wr_addr     (wr_addr),
      .fill_block  (bus.mem_rdata),
      .word_data   (bus.cpu_wdata)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge regardless of block order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      next_state    = state;
      bus.cpu_done  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.cpu_write)
               next_state = WRITE;
            else if (bus.cpu_read)
               next_state = lk_hit ? RESP : FILL;
         end
         FILL: begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready)
               next_state = RESP;
         end
         WRITE: begin
            bus.mem_write = 1'b1;
            if (bus.mem_ready)
               next_state = RESP;
         end
         RESP: begin
            bus.cpu_done = 1'b1;
            next_state   = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign bus.cpu_rdata = rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = wdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         mem_addr_q <= '0;
         num_hit    <= '0;
         num_miss   <= '0;
      end else begin
         if (accept) begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            // Block reads go out aligned; word writes carry the full address.
            mem_addr_q <= bus.cpu_write ? bus.cpu_addr
                                        : {bus.cpu_addr[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
            // On a read miss this capture is overwritten by the fill word.
            if (!bus.cpu_write)
               rdata_q <= lk_word;
            if (lk_hit) begin
               if (num_hit != '1)
                  num_hit <= num_hit + 1'b1;
            end else if (num_miss != '1) begin
               num_miss <= num_miss + 1'b1;
            end
         end
         if (fill_en)
            rdata_q <= fill_word;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and randomized accesses checked against a
// line-level cache model backed by a flat word memory.
module tb_dcache_ctrl;
   import cache_pkg::*;

   localparam int NL = 4;

   logic        clk;
   logic        reset_n;
   logic [15:0] num_hit, num_miss;

   dcache_ctrl_if #(.WORD_SIZE(16)) bus ();

   dcache_ctrl #(
      .NUM_LINES (NL),
      .WORD_SIZE (16)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .num_hit  (num_hit),
      .num_miss (num_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory and reference model ----------------
   logic [15:0] mem_words [65536];
   bit          m_valid [NL];
   int          m_tag   [NL];
   logic [15:0] m_hits, m_miss;

   function automatic int line_of(input logic [15:0] a);
      return (int'(a) / 4) % NL;
   endfunction

   function automatic int tag_of(input logic [15:0] a);
      return int'(a) / (4 * NL);
   endfunction

   function automatic bit model_hit(input logic [15:0] a);
      return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
   endfunction

   task automatic model_update(input bit wr, input logic [15:0] a, input bit hit);
      if (hit) begin
         if (m_hits != 16'hFFFF) m_hits++;
      end else begin
         if (m_miss != 16'hFFFF) m_miss++;
         if (!wr) begin
            m_valid[line_of(a)] = 1'b1;
            m_tag[line_of(a)]   = tag_of(a);
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_hits = '0;
      m_miss = '0;
   endtask

   // ---------------- access driver + memory responder ----------------
   typedef struct {
      logic [15:0] rdata;
      int          cycles;
      bit          saw_rd;
      bit          saw_wr;
      logic [15:0] maddr;
      logic [15:0] mwdata;
   } res_t;

   task automatic access(input bit wr, input bit both, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat, input string name,
                         output res_t r);
      int          mem_cnt;
      bit          done;
      logic [15:0] b;
      r = '{rdata: '0, cycles: 0, saw_rd: 1'b0, saw_wr: 1'b0, maddr: '0, mwdata: '0};
      @(negedge clk);
      bus.cpu_read  = !wr || both;
      bus.cpu_write = wr;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      mem_cnt = 0;
      done    = 1'b0;
      while (!done && r.cycles < 100) begin
         @(negedge clk);
         r.cycles++;
         bus.mem_ready = 1'b0;
         if (bus.cpu_done) begin
            r.rdata = bus.cpu_rdata;
            done    = 1'b1;
         end else if (bus.mem_read || bus.mem_write) begin
            r.saw_rd |= bus.mem_read;
            r.saw_wr |= bus.mem_write;
            r.maddr   = bus.mem_addr;
            r.mwdata  = bus.mem_wdata;
            if (mem_cnt == lat) begin
               bus.mem_ready = 1'b1;
               if (bus.mem_write) begin
                  mem_words[bus.mem_addr] = bus.mem_wdata;
               end else begin
                  b = {bus.mem_addr[15:2], 2'b00};
                  bus.mem_rdata = {mem_words[b + 16'd3], mem_words[b + 16'd2],
                                   mem_words[b + 16'd1], mem_words[b]};
               end
            end
            mem_cnt++;
         end
      end
      check({name, " completes"}, 64'(done), 64'd1);
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.mem_ready = 1'b0;
   endtask

   // Access whose expectations come entirely from the model and memory.
   task automatic run_checked(input bit wr, input bit both, input logic [15:0] addr,
                              input logic [15:0] wdata, input int lat, input string name);
      bit          hit;
      logic [15:0] exp_rd;
      res_t        r;
      hit    = model_hit(addr);
      exp_rd = mem_words[addr];
      access(wr, both, addr, wdata, lat, name, r);
      model_update(wr, addr, hit);
      check({name, " latency"}, 64'(r.cycles), 64'((!wr && hit) ? 1 : lat + 2));
      check({name, " mem_read seen"}, 64'(r.saw_rd), 64'(!wr && !hit));
      check({name, " mem_write seen"}, 64'(r.saw_wr), 64'(wr));
      if (!wr) check({name, " rdata"}, 64'(r.rdata), 64'(exp_rd));
      if (wr || !hit)
         check({name, " mem_addr"}, 64'(r.maddr), 64'(wr ? addr : {addr[15:2], 2'b00}));
      if (wr) check({name, " mem_wdata"}, 64'(r.mwdata), 64'(wdata));
      check({name, " num_hit"}, 64'(num_hit), 64'(m_hits));
      check({name, " num_miss"}, 64'(num_miss), 64'(m_miss));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] exp_rdata;
      int          exp_cycles;
      bit          exp_mrd;
      bit          exp_mwr;
      logic [15:0] exp_maddr;
      int          exp_hits;
      int          exp_miss;
   } vec_t;

   vec_t vecs [10];

   initial begin
      res_t r;
      bit   hit;

      for (int i = 0; i < 65536; i++) mem_words[i] = ~16'(i);
      mem_words[16'h0010] = 16'h4444;
      mem_words[16'h0011] = 16'h3333;
      mem_words[16'h0012] = 16'h2222;
      mem_words[16'h0013] = 16'h1111;
      model_reset();

      // Word 3 of a block is its top 16 bits; 0x0050 reads the ~addr pattern.
      vecs[0] = '{1'b0, 16'h0013, 16'h0000, 3, 16'h1111, 5, 1'b1, 1'b0, 16'h0010, 0, 1};
      vecs[1] = '{1'b0, 16'h0012, 16'h0000, 0, 16'h2222, 1, 1'b0, 1'b0, 16'h0000, 1, 1};
      vecs[2] = '{1'b1, 16'h0011, 16'hBEEF, 1, 16'h0000, 3, 1'b0, 1'b1, 16'h0011, 2, 1};
      vecs[3] = '{1'b0, 16'h0011, 16'h0000, 0, 16'hBEEF, 1, 1'b0, 1'b0, 16'h0000, 3, 1};
      vecs[4] = '{1'b1, 16'h0040, 16'h5A5A, 0, 16'h0000, 2, 1'b0, 1'b1, 16'h0040, 3, 2};
      vecs[5] = '{1'b0, 16'h0040, 16'h0000, 2, 16'h5A5A, 4, 1'b1, 1'b0, 16'h0040, 3, 3};
      vecs[6] = '{1'b0, 16'h0010, 16'h0000, 1, 16'h4444, 3, 1'b1, 1'b0, 16'h0010, 3, 4};
      vecs[7] = '{1'b0, 16'h0050, 16'h0000, 0, 16'hFFAF, 2, 1'b1, 1'b0, 16'h0050, 3, 5};
      vecs[8] = '{1'b0, 16'h0010, 16'h0000, 2, 16'h4444, 4, 1'b1, 1'b0, 16'h0010, 3, 6};
      vecs[9] = '{1'b0, 16'h0013, 16'h0000, 0, 16'h1111, 1, 1'b0, 1'b0, 16'h0000, 4, 6};

      reset_n       = 1'b0;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      #1;
      check("reset cpu_done", 64'(bus.cpu_done), 64'd0);
      check("reset mem_read", 64'(bus.mem_read), 64'd0);
      check("reset mem_write", 64'(bus.mem_write), 64'd0);
      check("reset cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
      check("reset mem_addr", 64'(bus.mem_addr), 64'd0);
      check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("reset num_hit", 64'(num_hit), 64'd0);
      check("reset num_miss", 64'(num_miss), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         string n;
         n = $sformatf("vec%0d", i);
         hit = model_hit(vecs[i].addr);
         access(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].lat, n, r);
         model_update(vecs[i].wr, vecs[i].addr, hit);
         check({n, " latency"}, 64'(r.cycles), 64'(vecs[i].exp_cycles));
         check({n, " mem_read seen"}, 64'(r.saw_rd), 64'(vecs[i].exp_mrd));
         check({n, " mem_write seen"}, 64'(r.saw_wr), 64'(vecs[i].exp_mwr));
         if (vecs[i].exp_mrd || vecs[i].exp_mwr)
            check({n, " mem_addr"}, 64'(r.maddr), 64'(vecs[i].exp_maddr));
         if (vecs[i].wr) check({n, " mem_wdata"}, 64'(r.mwdata), 64'(vecs[i].wdata));
         else            check({n, " rdata"}, 64'(r.rdata), 64'(vecs[i].exp_rdata));
         check({n, " num_hit"}, 64'(num_hit), 64'(vecs[i].exp_hits));
         check({n, " num_miss"}, 64'(num_miss), 64'(vecs[i].exp_miss));
      end

      // Request held through RESP: not taken there, re-sampled in IDLE.
      @(negedge clk);
      bus.cpu_read = 1'b1;
      bus.cpu_addr = 16'h0012;
      @(negedge clk);
      check("hold first done", 64'(bus.cpu_done), 64'd1);
      check("hold first rdata", 64'(bus.cpu_rdata), 64'h2222);
      @(negedge clk);
      check("hold no accept in RESP", 64'(bus.cpu_done), 64'd0);
      @(negedge clk);
      check("hold resampled done", 64'(bus.cpu_done), 64'd1);
      bus.cpu_read = 1'b0;
      model_update(1'b0, 16'h0012, 1'b1);
      model_update(1'b0, 16'h0012, 1'b1);
      check("hold num_hit", 64'(num_hit), 64'(m_hits));

      // Stray mem_ready in IDLE must be ignored.
      @(negedge clk);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      check("stray ready cpu_done", 64'(bus.cpu_done), 64'd0);
      check("stray ready mem_read", 64'(bus.mem_read), 64'd0);
      run_checked(1'b0, 1'b0, 16'h0012, 16'h0000, 0, "after stray ready");

      // Reset two cycles into a fill.
      @(negedge clk);
      bus.cpu_read = 1'b1;
      bus.cpu_addr = 16'h0021;
      @(negedge clk);
      check("abort fill started", 64'(bus.mem_read), 64'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort mem_read", 64'(bus.mem_read), 64'd0);
      check("abort cpu_done", 64'(bus.cpu_done), 64'd0);
      check("abort mem_addr", 64'(bus.mem_addr), 64'd0);
      check("abort num_hit", 64'(num_hit), 64'd0);
      check("abort num_miss", 64'(num_miss), 64'd0);
      bus.cpu_read = 1'b0;
      @(negedge clk);
      check("abort no done in reset", 64'(bus.cpu_done), 64'd0);
      reset_n = 1'b1;
      model_reset();
      run_checked(1'b0, 1'b0, 16'h0013, 16'h0000, 1, "post-reset miss");

      // Randomized traffic over a small address window to mix hits/conflicts.
      for (int i = 0; i < 150; i++) begin
         bit          wr;
         logic [15:0] a;
         wr = ($urandom_range(0, 9) < 3);
         a  = 16'($urandom_range(0, 95));
         run_checked(wr, wr && ($urandom_range(0, 1) == 1), a, 16'($urandom),
                     int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
